spi_temp_resp: RTL and testbench

SPI_TEMP_RESP -- requirements
Module: spi_temp_resp

---
 rtl/spi_temp_resp.sv | 162 ++++++++++++++++
 tb/tb_spi_temp_resp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_temp_resp.sv
// SPI mode-3 register responder for a temperature sensor; optional address auto-increment via SPI_TEMP_RESP_AUTOINC_EN.
// Latency: sck/cs/mosi edges act 3 clk after the pin changes (2-FF sync + edge detect); cfg_wr pulses 1 clk after the commit edge.
// Backpressure: none; the SPI controller paces the transfer, sck must not exceed clk/8.
module spi_temp_resp #(
  parameter logic [7:0] DEVICE_ID = 8'hA5,
  parameter logic [7:0] CFG_RST   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] temp_data,
  output logic [7:0]  cfg_reg,
  output logic        cfg_wr,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic       sck_meta, sck_sync, sck_prev;
  logic       cs_meta, cs_sync, cs_prev;
  logic       mosi_meta, mosi_sync;
  logic [1:0] sync_fill;
  logic       armed;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  addr;
  logic [6:0]  next_addr;
  logic [6:0]  rx_sh;
  logic [6:0]  tx_sh;
  logic [15:0] snap;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic        sck_rise, sck_fall, cs_fall, cs_rise, last_bit;

  // The synchronizers reset to idle levels, so a cs held low through reset would
  // look like a falling edge; armed only opens once a genuine high cs has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= 1'b1;
      sck_sync  <= 1'b1;
      sck_prev  <= 1'b1;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & cs_sync);
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_fall  = armed & cs_prev & ~cs_sync;
  assign cs_rise  = cs_sync & ~cs_prev;
  assign last_bit = (bit_cnt == 3'd0);
  assign rx_byte  = {rx_sh, mosi_sync};

`ifdef SPI_TEMP_RESP_AUTOINC_EN
  assign next_addr = addr + 7'd1;
`else
  assign next_addr = addr;
`endif

  always_comb begin
    rd_byte = 8'h00;
    case (addr)
      7'h00:   rd_byte = snap[15:8];
      7'h01:   rd_byte = snap[7:0];
      7'h02:   rd_byte = cfg_reg;
      7'h03:   rd_byte = DEVICE_ID;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      miso    <= 1'b0;
      cfg_reg <= CFG_RST;
      cfg_wr  <= 1'b0;
      busy    <= 1'b0;
      snap    <= 16'h0000;
      bit_cnt <= 3'd7;
      addr    <= 7'h00;
      rx_sh   <= 7'h00;
      tx_sh   <= 7'h00;
    end else begin
      cfg_wr <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        busy  <= 1'b0;
        miso  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              busy    <= 1'b1;
              snap    <= temp_data;
              bit_cnt <= 3'd7;
            end
          end
          CMD: begin
            if (sck_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt - 3'd1;
              if (last_bit) begin
                addr  <= rx_byte[6:0];
                state <= rx_byte[7] ? RD : WR;
              end
            end
          end
          RD: begin
            // bit_cnt sits at 7 only on the falling edge that opens a new byte
            if (sck_fall) begin
              if (bit_cnt == 3'd7) {miso, tx_sh} <= rd_byte;
              else                 {miso, tx_sh} <= {tx_sh, 1'b0};
            end
            if (sck_rise) begin
              bit_cnt <= bit_cnt - 3'd1;
              if (last_bit) addr <= next_addr;
            end
          end
          WR: begin
            if (sck_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt - 3'd1;
              if (last_bit) begin
                if (addr == 7'h02) begin
                  cfg_reg <= rx_byte;
                  cfg_wr  <= 1'b1;
                end
                addr <= next_addr;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_temp_resp.sv
// Directed bench for spi_temp_resp: an SPI controller drives frames, a register-map model predicts read bytes.
// Latency: n/a (bench). Backpressure: n/a (bench).
// A background process checks miso/cfg_reg/cfg_wr on every clk while they are meaningful.
module tb_spi_temp_resp;

  localparam logic [7:0] DEV_ID  = 8'hA5;
  localparam logic [7:0] CFG_DEF = 8'h00;
  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] temp_data = 16'h0000;
  logic [7:0]  cfg_reg;
  logic        cfg_wr;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  logic [7:0] m_cfg = CFG_DEF;
  logic chk_quiet = 1'b0;
  logic chk_cfg = 1'b0;
  logic cfg_wr_q = 1'b0;
  logic [7:0] rd_got [0:7];

  spi_temp_resp #(.DEVICE_ID(DEV_ID), .CFG_RST(CFG_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .temp_data(temp_data), .cfg_reg(cfg_reg), .cfg_wr(cfg_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a, input logic [15:0] s);
    case (a)
      7'h00:   return s[15:8];
      7'h01:   return s[7:0];
      7'h02:   return m_cfg;
      7'h03:   return DEV_ID;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [6:0] m_next(input logic [6:0] a);
`ifdef SPI_TEMP_RESP_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_quiet) check("miso_quiet", {31'd0, miso}, 32'd0);
      if (chk_cfg) check("cfg_reg_track", {24'd0, cfg_reg}, {24'd0, m_cfg});
      if (cfg_wr) check("cfg_wr_single_clk", {31'd0, cfg_wr_q}, 32'd0);
      if (cfg_wr && !cfg_wr_q) wr_pulses++;
      cfg_wr_q <= cfg_wr;
    end else begin
      cfg_wr_q <= 1'b0;
    end
  end

  // One mode-3 byte (or its first nbits): change mosi on the falling edge, sample miso on the rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sck = 1'b0;
      mosi = tx[i];
      #HALF;
      sck = 1'b1;
      rx[i] = miso;
      #HALF;
    end
  endtask

  task automatic rd_frame(input logic [7:0] cmd, input int n, input logic scramble);
    logic [7:0] rx;
    logic [6:0] a;
    logic [15:0] s;
    int p0;
    p0 = wr_pulses;
    s = temp_data;
    cs = 1'b0;
    #100;
    xfer(cmd, 8, rx);
    if (scramble) temp_data = ~temp_data;
    a = cmd[6:0];
    chk_quiet = 1'b0;
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rx);
      rd_got[k] = rx;
      check("rd_byte_model", {24'd0, rx}, {24'd0, m_read(a, s)});
      a = m_next(a);
    end
    #100;
    cs = 1'b1;
    #200;
    chk_quiet = 1'b1;
    check("rd_frame_no_cfg_wr", wr_pulses, p0);
    check("rd_frame_busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] rx;
    logic [7:0] new_cfg;
    logic [6:0] a;
    int p0;
    int exp_p;
    p0 = wr_pulses;
    exp_p = 0;
    new_cfg = m_cfg;
    cs = 1'b0;
    #100;
    chk_cfg = 1'b0;
    xfer(cmd, 8, rx);
    a = cmd[6:0];
    for (int k = 0; k < n; k++) begin
      xfer((k == 0) ? d0 : d1, 8, rx);
      if (a == 7'h02) begin
        new_cfg = (k == 0) ? d0 : d1;
        exp_p++;
      end
      a = m_next(a);
    end
    #100;
    cs = 1'b1;
    #200;
    m_cfg = new_cfg;
    chk_cfg = 1'b1;
    check("wr_frame_pulses", wr_pulses - p0, exp_p);
    check("wr_frame_cfg", {24'd0, cfg_reg}, {24'd0, new_cfg});
  endtask

  initial begin
    logic [7:0] rx;
    int p0;
    #3;
    #20;
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_cfg_reg", {24'd0, cfg_reg}, {24'd0, CFG_DEF});
    check("reset_cfg_wr", {31'd0, cfg_wr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #100;
    chk_quiet = 1'b1;
    chk_cfg = 1'b1;

    // Snapshot coherence: temp_data changes right after the command byte.
    temp_data = 16'h1234;
    rd_frame(8'h80, 2, 1'b1);
    check("lit_temp_hi", {24'd0, rd_got[0]}, 32'h12);
`ifdef SPI_TEMP_RESP_AUTOINC_EN
    check("lit_temp_lo", {24'd0, rd_got[1]}, 32'h34);
`else
    check("lit_temp_repeat", {24'd0, rd_got[1]}, 32'h12);
`endif
    temp_data = 16'h1234;

    wr_frame(8'h02, 1, 8'h5C, 8'h00);
    check("lit_cfg_written", {24'd0, cfg_reg}, 32'h5C);
    rd_frame(8'h82, 1, 1'b0);
    check("lit_cfg_readback", {24'd0, rd_got[0]}, 32'h5C);
    rd_frame(8'h83, 1, 1'b0);
    check("lit_device_id", {24'd0, rd_got[0]}, 32'hA5);
    rd_frame(8'h90, 1, 1'b0);
    check("lit_unmapped", {24'd0, rd_got[0]}, 32'h00);

    // Partial byte then cs high: nothing commits, busy drops within 3 clk.
    p0 = wr_pulses;
    cs = 1'b0;
    #100;
    chk_cfg = 1'b0;
    xfer(8'h02, 8, rx);
    xfer(8'hFF, 5, rx);
    check("partial_busy_high", {31'd0, busy}, 32'd1);
    #100;
    cs = 1'b1;
    #30;
    check("partial_busy_3clk", {31'd0, busy}, 32'd0);
    #170;
    chk_cfg = 1'b1;
    check("partial_no_cfg_wr", wr_pulses, p0);
    check("partial_cfg_kept", {24'd0, cfg_reg}, 32'h5C);

    rd_frame(8'h82, 3, 1'b0);
    check("lit_multi0", {24'd0, rd_got[0]}, 32'h5C);
`ifdef SPI_TEMP_RESP_AUTOINC_EN
    check("lit_multi1", {24'd0, rd_got[1]}, 32'hA5);
    check("lit_multi2", {24'd0, rd_got[2]}, 32'h00);
`else
    check("lit_multi1", {24'd0, rd_got[1]}, 32'h5C);
    check("lit_multi2", {24'd0, rd_got[2]}, 32'h5C);
`endif

    // sck activity with cs high, and a cs pulse with no sck, must both be inert.
    p0 = wr_pulses;
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0;
      #HALF;
      sck = 1'b1;
      #HALF;
    end
    mosi = 1'b0;
    cs = 1'b0;
    #200;
    cs = 1'b1;
    #200;
    check("idle_no_cfg_wr", wr_pulses, p0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    rd_frame(8'h83, 1, 1'b0);

    wr_frame(8'h05, 1, 8'h77, 8'h00);
    wr_frame(8'h02, 2, 8'h3C, 8'h5C);
    wr_frame(8'h01, 2, 8'h11, 8'h22);
    temp_data = 16'hC3E1;
    rd_frame(8'hFF, 2, 1'b0);
    rd_frame(8'h81, 1, 1'b0);
    check("lit_temp_lo_byte", {24'd0, rd_got[0]}, 32'hE1);

    // Reset in the middle of a read byte whose current bit is a 1.
    temp_data = 16'hBEEF;
    cs = 1'b0;
    #100;
    xfer(8'h80, 8, rx);
    chk_quiet = 1'b0;
    xfer(8'h00, 4, rx);
    check("pre_reset_miso", {31'd0, miso}, 32'd1);
    rst_n = 1'b0;
    m_cfg = CFG_DEF;
    #10;
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_cfg_reg", {24'd0, cfg_reg}, {24'd0, CFG_DEF});
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
    #20;
    rst_n = 1'b1;
    chk_quiet = 1'b1;
    #100;
    check("postrst_busy_cs_low", {31'd0, busy}, 32'd0);
    p0 = wr_pulses;
    xfer(8'h02, 8, rx);
    xfer(8'h5C, 8, rx);
    #100;
    check("postrst_ignored_wr", wr_pulses, p0);
    check("postrst_cfg_kept", {24'd0, cfg_reg}, {24'd0, CFG_DEF});
    cs = 1'b1;
    #200;
    temp_data = 16'h1234;
    rd_frame(8'h80, 1, 1'b0);
    check("lit_postrst_read", {24'd0, rd_got[0]}, 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
